pfilter_cfg_master: RTL

// Avalon-MM initiator that programs the packet filter's NUM_REGS-word register file and verifies it.
// On start_i it writes every word from cfg_data_i, reads each one back, compares it under CHECK_MASK, and reports done/error.

---
 rtl/pfilter_pkg.sv | 25 ++
 rtl/pfilter_cfg_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pfilter_pkg.sv
// Shared definitions for the packet filter and its configuration master:
// master FSM states and the filter's register map.
package pfilter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        FIN   = 3'd4
    } amm_state_t;

    // Word addresses of the packet_filter register file.
    localparam int unsigned PF_REG_CTRL   = 0;
    localparam int unsigned PF_REG_MATCH  = 1;
    localparam int unsigned PF_REG_MASK   = 2;
    localparam int unsigned PF_REG_STATUS = 3;
    localparam int unsigned PF_NUM_REGS   = 4;

    // Address width for a word-addressed file; never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pfilter_cfg_master.sv
// Avalon-MM initiator: writes NUM_REGS configuration words into the packet
// filter, reads each one back, and flags the first mismatch or read timeout.
module pfilter_cfg_master
    import pfilter_pkg::*;
#(
    parameter int                  AMM_DWIDTH  = 32,
    parameter int                  NUM_REGS    = 4,
    parameter int                  AWIDTH      = addr_width(NUM_REGS),
    parameter logic [NUM_REGS-1:0] CHECK_MASK  = {NUM_REGS{1'b1}},
    parameter int                  TIMEOUT_CYC = 64
) (
    input  logic                           clk_i,
    input  logic                           srst_i,
    input  logic                           start_i,
    input  logic [NUM_REGS*AMM_DWIDTH-1:0] cfg_data_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [AWIDTH-1:0]              err_idx_o,
    output logic [AWIDTH-1:0]              amm_address_o,
    output logic                           amm_write_o,
    output logic [AMM_DWIDTH-1:0]          amm_writedata_o,
    output logic                           amm_read_o,
    input  logic                           amm_waitrequest_i,
    input  logic [AMM_DWIDTH-1:0]          amm_readdata_i,
    input  logic                           amm_readdatavalid_i
);

    localparam int         TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [AWIDTH-1:0] IDX_LAST = AWIDTH'(NUM_REGS - 1);

    amm_state_t            r_state;
    amm_state_t            w_state_nxt;
    logic [AWIDTH-1:0]     r_idx;
    logic [AWIDTH-1:0]     w_idx_nxt;
    logic [TW-1:0]         r_tmo;
    logic [TW-1:0]         w_tmo_nxt;
    logic                  r_err;
    logic [AWIDTH-1:0]     r_err_idx;
    logic [AMM_DWIDTH-1:0] r_shadow [NUM_REGS];
    logic                  w_load;
    logic                  w_fail;
    logic                  w_last;
    logic                  w_mismatch;

    assign w_last     = (r_idx == IDX_LAST);
    assign w_mismatch = CHECK_MASK[r_idx] && (amm_readdata_i != r_shadow[r_idx]);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tmo_nxt   = r_tmo;
        w_load      = 1'b0;
        w_fail      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = WR;
                end
            end
            WR: begin
                if (!amm_waitrequest_i) begin
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = RD;
                    end else begin
                        w_idx_nxt = r_idx + AWIDTH'(1);
                    end
                end
            end
            RD: begin
                if (!amm_waitrequest_i) begin
                    w_tmo_nxt   = '0;
                    w_state_nxt = RWAIT;
                end
            end
            RWAIT: begin
                // A valid beat in the last timeout cycle still counts as a response.
                if (amm_readdatavalid_i) begin
                    w_fail    = w_mismatch;
                    w_tmo_nxt = '0;
                    if (w_last) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_idx_nxt   = r_idx + AWIDTH'(1);
                        w_state_nxt = RD;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_fail      = 1'b1;
                    w_tmo_nxt   = '0;
                    w_state_nxt = FIN;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (srst_i) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tmo   <= w_tmo_nxt;
            if (w_load) begin
                r_err     <= 1'b0;
                r_err_idx <= '0;
            end else if (w_fail && !r_err) begin
                r_err     <= 1'b1;
                r_err_idx <= r_idx;
            end
        end
    end

    // NOTE: the shadow words are not reset; they are only read after a start has loaded them.
    always_ff @(posedge clk_i) begin
        if (w_load) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= cfg_data_i[i*AMM_DWIDTH +: AMM_DWIDTH];
            end
        end
    end

    always_comb begin
        busy_o          = (r_state != IDLE);
        done_o          = (r_state == FIN);
        err_o           = r_err;
        err_idx_o       = r_err_idx;
        amm_write_o     = (r_state == WR);
        amm_read_o      = (r_state == RD);
        amm_address_o   = '0;
        amm_writedata_o = '0;
        if (r_state == WR || r_state == RD) begin
            amm_address_o = r_idx;
        end
        if (r_state == WR) begin
            amm_writedata_o = r_shadow[r_idx];
        end
    end

endmodule
